// File: rtl/pipelined_carry_increment_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_carry_increment_adder
// Brief    : Pipelined carry-increment adder/subtractor with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_carry_increment_adder #(
    parameter int WIDTH            = 16,
    parameter int BLOCK            = 4,
    parameter int BLOCKS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NB = WIDTH / BLOCK;
    localparam int L  = NB / BLOCKS_PER_STAGE;

    logic             en_w;
    logic [WIDTH-1:0] bx_w;
    logic             cx_w;
    logic [WIDTH-1:0] s0_w;
    logic [NB-1:0]    c0_w;

    logic [WIDTH-1:0] s_d  [L];
    logic [WIDTH-1:0] s_q  [L];
    logic [NB-1:0]    c0_d [L];
    logic [NB-1:0]    c0_q [L];
    logic             cy_d [L];
    logic             cy_q [L];
    logic             px_d [L];
    logic             px_q [L];
    logic             v_d  [L];
    logic             v_q  [L];

    assign en_w     = ~v_q[L-1] | out_ready;
    assign in_ready = en_w & ~rst;
    assign bx_w     = sub ? ~b : b;
    assign cx_w     = carry_in ^ sub;

    always_comb begin : acc_blocks
        logic [BLOCK:0] t;
        t    = '0;
        s0_w = '0;
        c0_w = '0;
        for (int j = 0; j < NB; j++) begin
            t = {1'b0, a[j*BLOCK +: BLOCK]} + {1'b0, bx_w[j*BLOCK +: BLOCK]};
            s0_w[j*BLOCK +: BLOCK] = t[BLOCK-1:0];
            c0_w[j]                = t[BLOCK];
        end
    end

    always_comb begin : resolve
        logic [WIDTH-1:0] in_s  [L];
        logic [NB-1:0]    in_c0 [L];
        logic             in_cy [L];
        logic             in_px [L];
        logic             in_v  [L];
        logic [WIDTH-1:0] ts;
        logic             tcy;
        logic [BLOCK-1:0] blk;
        int               j;
        ts  = '0;
        tcy = 1'b0;
        blk = '0;
        j   = 0;
        for (int k = 0; k < L; k++) begin
            in_s[k]  = '0;
            in_c0[k] = '0;
            in_cy[k] = 1'b0;
            in_px[k] = 1'b0;
            in_v[k]  = 1'b0;
            s_d[k]   = '0;
            c0_d[k]  = '0;
            cy_d[k]  = 1'b0;
            px_d[k]  = 1'b0;
            v_d[k]   = 1'b0;
        end
        // px carries a^bx at the MSB so the carry into the MSB can be recovered from the final sum bit
        in_s[0]  = s0_w;
        in_c0[0] = c0_w;
        in_cy[0] = cx_w;
        in_px[0] = a[WIDTH-1] ^ bx_w[WIDTH-1];
        in_v[0]  = in_valid;
        for (int k = 1; k < L; k++) begin
            in_s[k]  = s_q[k-1];
            in_c0[k] = c0_q[k-1];
            in_cy[k] = cy_q[k-1];
            in_px[k] = px_q[k-1];
            in_v[k]  = v_q[k-1];
        end
        for (int k = 0; k < L; k++) begin
            ts  = in_s[k];
            tcy = in_cy[k];
            for (int i = 0; i < BLOCKS_PER_STAGE; i++) begin
                j   = k * BLOCKS_PER_STAGE + i;
                blk = ts[j*BLOCK +: BLOCK];
                ts[j*BLOCK +: BLOCK] = blk + {{(BLOCK-1){1'b0}}, tcy};
                tcy = in_c0[k][j] | (tcy & (&blk));
            end
            s_d[k]  = ts;
            c0_d[k] = in_c0[k];
            cy_d[k] = tcy;
            px_d[k] = in_px[k];
            v_d[k]  = in_v[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                v_q[k]  <= 1'b0;
                s_q[k]  <= '0;
                c0_q[k] <= '0;
                cy_q[k] <= 1'b0;
                px_q[k] <= 1'b0;
            end
        end else if (en_w) begin
            for (int k = 0; k < L; k++) begin
                v_q[k]  <= v_d[k];
                s_q[k]  <= s_d[k];
                c0_q[k] <= c0_d[k];
                cy_q[k] <= cy_d[k];
                px_q[k] <= px_d[k];
            end
        end
    end

    assign out_valid = v_q[L-1];
    assign sum       = s_q[L-1];
    assign carry_out = cy_q[L-1];
    assign overflow  = s_q[L-1][WIDTH-1] ^ px_q[L-1] ^ cy_q[L-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_increment_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_carry_increment_adder
// Brief    : Directed-vector bench for the pipelined carry-increment adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_carry_increment_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        carry_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] va [14];
    logic [15:0] vb [14];
    logic        vc [14];
    logic        vs [14];
    logic [15:0] es [14];
    logic        eco[14];
    logic        eov[14];

    always #5 clk = ~clk;

    pipelined_carry_increment_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [15:0] ai, input logic [15:0] bi,
                           input logic ci, input logic si, input logic [15:0] e,
                           input logic co, input logic ov);
        va[i] = ai; vb[i] = bi; vc[i] = ci; vs[i] = si;
        es[i] = e;  eco[i] = co; eov[i] = ov;
    endtask

    task automatic drive(input int i);
        a = va[i]; b = vb[i]; carry_in = vc[i]; sub = vs[i]; in_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, overflow, carry_out, sum} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b ov=%b co=%b sum=%h want all zero",
                     out_valid, overflow, carry_out, sum);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed;
        for (int i = 0; i < 6; i++) begin
            drive(i);
            tick();
            in_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL dir_early_valid[%0d] cyc %0d got %b want 0", i, c, out_valid);
                end
                tick();
            end
            checks++;
            if (out_valid !== 1'b1 || {overflow, carry_out, sum} !== {eov[i], eco[i], es[i]}) begin
                errors++;
                $display("FAIL dir_result[%0d] got v=%b sum=%h co=%b ov=%b want v=1 sum=%h co=%b ov=%b",
                         i, out_valid, sum, carry_out, overflow, es[i], eco[i], eov[i]);
            end
        end
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive(6 + c);
            else in_valid = 1'b0;
            tick();
            checks++;
            if (c < 3) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_early_valid cyc %0d got %b want 0", c, out_valid);
                end
            end else if (out_valid !== 1'b1 ||
                         {overflow, carry_out, sum} !== {eov[3+c], eco[3+c], es[3+c]}) begin
                errors++;
                $display("FAIL b2b_result[%0d] got v=%b sum=%h co=%b ov=%b want v=1 sum=%h co=%b ov=%b",
                         c - 3, out_valid, sum, carry_out, overflow, es[3+c], eco[3+c], eov[3+c]);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        for (int c = 0; c < 4; c++) begin
            drive(6 + c);
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || sum !== es[6]) begin
            errors++;
            $display("FAIL bp_first got v=%b sum=%h want v=1 sum=%h", out_valid, sum, es[6]);
        end
        out_ready = 1'b0;
        drive(10);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {overflow, carry_out, sum} !== {eov[6], eco[6], es[6]}) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b rdy=%b sum=%h co=%b ov=%b want v=1 rdy=0 sum=%h co=%b ov=%b",
                         c, out_valid, in_ready, sum, carry_out, overflow, es[6], eco[6], eov[6]);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(10);
            else if (k == 1) drive(11);
            else in_valid = 1'b0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || {overflow, carry_out, sum} !== {eov[7+k], eco[7+k], es[7+k]}) begin
                errors++;
                $display("FAIL bp_drain[%0d] got v=%b sum=%h co=%b ov=%b want v=1 sum=%h co=%b ov=%b",
                         k, out_valid, sum, carry_out, overflow, es[7+k], eco[7+k], eov[7+k]);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_tail_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight;
        drive(12); tick();
        drive(13); tick();
        drive(6);  tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({out_valid, overflow, carry_out, sum} !== 19'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got v=%b sum=%h co=%b ov=%b rdy=%b want all zero",
                     out_valid, sum, carry_out, overflow, in_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_ghost cyc %0d got v=%b sum=%h want v=0", c, out_valid, sum);
            end
        end
        drive(8);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_early cyc %0d got %b want 0", c, out_valid);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || {overflow, carry_out, sum} !== {eov[8], eco[8], es[8]}) begin
            errors++;
            $display("FAIL midrst_after got v=%b sum=%h co=%b ov=%b want v=1 sum=%h co=%b ov=%b",
                     out_valid, sum, carry_out, overflow, es[8], eco[8], eov[8]);
        end
    endtask

    initial begin
        set_vec(0,  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        set_vec(1,  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        set_vec(2,  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        set_vec(3,  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        set_vec(4,  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        set_vec(5,  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        set_vec(6,  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        set_vec(7,  16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        set_vec(8,  16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        set_vec(9,  16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        set_vec(10, 16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
        set_vec(11, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        set_vec(12, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        set_vec(13, 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
